// File: rtl/mux_tdm.sv
// Registered N:1 mux with a round-robin time-division scan mode.
// Manual mode forwards channel s; scan mode walks the enabled channels and tags each word with its index.

module mux_tdm_lane #(
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic             req,
  input  logic [SEL_W-1:0] ptr,
  output logic             req_hi
);
  localparam logic [SEL_W-1:0] IDX_V = SEL_W'(IDX);

  // Request from this lane that lies at or after the scan pointer.
  assign req_hi = req && (IDX_V >= ptr);
endmodule

module mux_tdm #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]          s,
  input  logic                      mode,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       ch_en,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          ch,
  output logic                      valid,
  output logic                      wrap
);
  localparam logic [SEL_W:0]   CH_LIM = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST   = SEL_W'(CHANNELS-1);

  logic [CHANNELS-1:0][WIDTH-1:0] d_arr;
  logic [SEL_W-1:0]               ptr;
  logic [CHANNELS-1:0]            req_hi;
  logic [SEL_W-1:0]               pick_hi, pick_lo, pick, last_en, ptr_nxt;
  logic                           any_en, s_ok;

  assign d_arr = d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    mux_tdm_lane #(.SEL_W(SEL_W), .IDX(i)) u_lane (
      .req    (ch_en[i]),
      .ptr    (ptr),
      .req_hi (req_hi[i])
    );
  end

  // Circular pick: lowest request at/after ptr, else lowest request overall.
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    last_en = '0;
    for (int i = CHANNELS-1; i >= 0; i--) begin
      if (ch_en[i])  pick_lo = SEL_W'(i);
      if (req_hi[i]) pick_hi = SEL_W'(i);
    end
    for (int i = 0; i < CHANNELS; i++)
      if (ch_en[i]) last_en = SEL_W'(i);
    any_en  = |ch_en;
    pick    = (|req_hi) ? pick_hi : pick_lo;
    ptr_nxt = (pick == LAST) ? '0 : pick + SEL_W'(1);
    s_ok    = {1'b0, s} < CH_LIM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out   <= '0;
      ch    <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
      ptr   <= '0;
    end else begin
      valid <= 1'b0;
      wrap  <= 1'b0;
      // Manual mode parks the pointer so every scan entry starts at channel 0.
      if (!mode) ptr <= '0;
      if (en) begin
        if (!mode) begin
          ch <= s;
          if (s_ok) begin
            out   <= d_arr[s];
            valid <= 1'b1;
          end else begin
            out <= '0;
          end
        end else if (any_en) begin
          out   <= d_arr[pick];
          ch    <= pick;
          valid <= 1'b1;
          wrap  <= (pick == last_en);
          ptr   <= ptr_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_mux_tdm.sv
// Scoreboard bench for mux_tdm: a behavioural model pushes expected words as stimulus is
// driven; each scenario task pops and compares them after the clock edge.

module tb_mux_tdm;
  typedef struct packed {
    logic [7:0] out;
    logic [1:0] ch;
    logic       valid;
    logic       wrap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] d = '0;
  logic [1:0]  s = '0;
  logic        mode = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  ch_en = '0;
  logic [7:0]  out;
  logic [1:0]  ch;
  logic        valid, wrap;

  logic [23:0] d3 = '0;
  logic [1:0]  s3 = '0;
  logic        en3 = 1'b0;
  logic [7:0]  out3;
  logic [1:0]  ch3;
  logic        valid3, wrap3;

  int errors = 0;
  int checks = 0;

  exp_t       sb[$];
  logic [7:0] m_out = '0;
  logic [1:0] m_ch = '0;
  int         m_ptr = 0;

  always #5 clk = ~clk;

  mux_tdm #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .d(d), .s(s), .mode(mode), .en(en), .ch_en(ch_en),
    .out(out), .ch(ch), .valid(valid), .wrap(wrap)
  );

  mux_tdm #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .d(d3), .s(s3), .mode(1'b0), .en(en3), .ch_en(3'b000),
    .out(out3), .ch(ch3), .valid(valid3), .wrap(wrap3)
  );

  // Behavioural model of the 4-channel instance: walks the circular order explicitly.
  task automatic push_exp();
    exp_t e;
    int   pick, hi;
    bit   found;
    e = '0;
    if (en) begin
      if (!mode) begin
        m_ch  = s;
        m_out = d[s*8 +: 8];
        e.valid = 1'b1;
      end else begin
        found = 0; pick = 0; hi = 0;
        for (int j = 0; j < 4; j++) begin
          if (!found && ch_en[(m_ptr + j) % 4]) begin
            found = 1;
            pick  = (m_ptr + j) % 4;
          end
        end
        for (int k = 0; k < 4; k++) if (ch_en[k]) hi = k;
        if (found) begin
          m_out   = d[pick*8 +: 8];
          m_ch    = 2'(pick);
          e.valid = 1'b1;
          e.wrap  = (pick == hi);
          m_ptr   = (pick + 1) % 4;
        end
      end
    end
    if (!mode) m_ptr = 0;
    e.out = m_out;
    e.ch  = m_ch;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_out = '0; m_ch = '0; m_ptr = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({out, ch, valid, wrap} !== 12'h000) begin
      errors++;
      $display("FAIL reset: got out=%h ch=%0d v=%b w=%b, want all zero", out, ch, valid, wrap);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_manual();
    logic [31:0] dv[3];
    logic [1:0]  sv[3];
    logic [7:0]  want_out[3];
    exp_t e;
    dv = '{32'h01010100, 32'h00000100, 32'h01000000};
    sv = '{2'd0, 2'd1, 2'd3};
    want_out = '{8'h00, 8'h01, 8'h01};
    mode = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = dv[i]; s = sv[i];
      push_exp();
      if (i == 2) begin
        #1;
        checks++;
        if (ch !== 2'd1) begin
          errors++;
          $display("FAIL manual_latency: ch=%0d before edge, want 1", ch);
        end
      end
      tick();
      e = sb.pop_front();
      checks++;
      if ({out, ch, valid, wrap} !== e || out !== want_out[i] || ch !== sv[i] || valid !== 1'b1) begin
        errors++;
        $display("FAIL manual[%0d]: got out=%h ch=%0d v=%b w=%b, want out=%h ch=%0d v=1 w=0",
                 i, out, ch, valid, wrap, want_out[i], sv[i]);
      end
    end
  endtask

  task automatic test_full_scan();
    logic [1:0] want_ch[6];
    exp_t e;
    want_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    d = 32'h44332211; ch_en = 4'b1111; mode = 1'b1; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_exp();
      tick();
      e = sb.pop_front();
      checks++;
      if ({out, ch, valid, wrap} !== e || ch !== want_ch[i] || wrap !== (want_ch[i] == 2'd3)) begin
        errors++;
        $display("FAIL full_scan[%0d]: got out=%h ch=%0d v=%b w=%b, want out=%h ch=%0d v=%b w=%b",
                 i, out, ch, valid, wrap, e.out, e.ch, e.valid, e.wrap);
      end
    end
  endtask

  task automatic test_masked_scan();
    logic [1:0] want_ch[6];
    exp_t e;
    want_ch = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd0};
    mode = 1'b0; en = 1'b1; s = 2'd0;
    push_exp(); tick(); void'(sb.pop_front());
    mode = 1'b1; ch_en = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) ch_en = 4'b0001;
      push_exp();
      tick();
      e = sb.pop_front();
      checks++;
      if ({out, ch, valid, wrap} !== e || ch !== want_ch[i] || wrap !== (i == 1 || i == 3 || i == 5)) begin
        errors++;
        $display("FAIL masked_scan[%0d]: got out=%h ch=%0d v=%b w=%b, want out=%h ch=%0d v=%b w=%b",
                 i, out, ch, valid, wrap, e.out, e.ch, e.valid, e.wrap);
      end
    end
  endtask

  task automatic test_hold_empty();
    exp_t e;
    mode = 1'b0; en = 1'b1;
    push_exp(); tick(); void'(sb.pop_front());
    mode = 1'b1; ch_en = 4'b1111; d = 32'h44332211;
    for (int i = 0; i < 8; i++) begin
      en = !(i >= 2 && i <= 4);
      if (i == 6) ch_en = 4'b0000;
      push_exp();
      tick();
      e = sb.pop_front();
      checks++;
      if ({out, ch, valid, wrap} !== e ||
          (i >= 2 && i <= 4 && (ch !== 2'd1 || out !== 8'h22 || valid !== 1'b0)) ||
          (i == 5 && ch !== 2'd2) || (i >= 6 && (ch !== 2'd2 || valid !== 1'b0))) begin
        errors++;
        $display("FAIL hold_empty[%0d]: got out=%h ch=%0d v=%b w=%b, want out=%h ch=%0d v=%b w=%b",
                 i, out, ch, valid, wrap, e.out, e.ch, e.valid, e.wrap);
      end
    end
  endtask

  task automatic test_out_of_range();
    d3 = 24'hC3B2A1; en3 = 1'b1; s3 = 2'd2;
    tick();
    checks++;
    if (out3 !== 8'hC3 || ch3 !== 2'd2 || valid3 !== 1'b1 || wrap3 !== 1'b0) begin
      errors++;
      $display("FAIL oor_inrange: got out=%h ch=%0d v=%b w=%b, want out=c3 ch=2 v=1 w=0",
               out3, ch3, valid3, wrap3);
    end
    s3 = 2'd3;
    tick();
    checks++;
    if (out3 !== 8'h00 || ch3 !== 2'd3 || valid3 !== 1'b0 || wrap3 !== 1'b0) begin
      errors++;
      $display("FAIL oor_s3: got out=%h ch=%0d v=%b w=%b, want out=00 ch=3 v=0 w=0",
               out3, ch3, valid3, wrap3);
    end
    en3 = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    exp_t e;
    mode = 1'b0; en = 1'b1;
    push_exp(); tick(); void'(sb.pop_front());
    mode = 1'b1; ch_en = 4'b1111; d = 32'h44332211;
    for (int i = 0; i < 3; i++) begin
      push_exp(); tick(); void'(sb.pop_front());
    end
    checks++;
    if (ch !== 2'd2 || out !== 8'h33) begin
      errors++;
      $display("FAIL pre_reset: got out=%h ch=%0d, want out=33 ch=2", out, ch);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out, ch, valid, wrap} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got out=%h ch=%0d v=%b w=%b, want all zero", out, ch, valid, wrap);
    end
    #1;
    rst_n = 1'b1;
    model_reset();
    push_exp();
    tick();
    e = sb.pop_front();
    checks++;
    if ({out, ch, valid, wrap} !== e || ch !== 2'd0 || out !== 8'h11) begin
      errors++;
      $display("FAIL post_reset: got out=%h ch=%0d v=%b w=%b, want out=11 ch=0 v=1 w=0",
               out, ch, valid, wrap);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      d     = $urandom;
      s     = 2'($urandom_range(0, 3));
      mode  = ($urandom_range(0, 4) != 0);
      en    = ($urandom_range(0, 5) != 0);
      ch_en = 4'($urandom_range(0, 15));
      push_exp();
      tick();
      e = sb.pop_front();
      checks++;
      if ({out, ch, valid, wrap} !== e) begin
        errors++;
        $display("FAIL random[%0d]: got out=%h ch=%0d v=%b w=%b, want out=%h ch=%0d v=%b w=%b",
                 i, out, ch, valid, wrap, e.out, e.ch, e.valid, e.wrap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_full_scan();
    test_masked_scan();
    test_hold_empty();
    test_out_of_range();
    test_reset_mid_scan();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
